// File: rtl/rs_frame_buffer_ctrl.sv
// rs_frame_buffer_ctrl: sequences one RS frame through the single-port symbol RAM.
// FILL writes FRAME_LEN upstream symbols, DRAIN reads them back through a
// 2-entry output FIFO that hides the RAM's one-cycle, high-Z-when-idle read port.
// Optional build macro RS_FRAME_REVERSE_EN: drain addresses FRAME_LEN-1 down to 0.
module rs_frame_buffer_ctrl #(
  parameter int WORDS     = 32,
  parameter int AW        = 5,
  parameter int DW        = 16,
  parameter int FRAME_LEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          ram_ren,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  // A frame can never be longer than the RAM it lives in.
  localparam int          FL_EFF    = (FRAME_LEN > WORDS) ? WORDS : FRAME_LEN;
  localparam logic [AW:0] LAST_IDX  = (AW+1)'(FL_EFF - 1);
  localparam logic [AW:0] FRAME_CNT = (AW+1)'(FL_EFF);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] PTR_ZERO  = (AW+1)'(0);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic [DW-1:0] fifo_data_q [2];
  logic [DW-1:0] fifo_data_d [2];
  logic          fifo_last_q [2];
  logic          fifo_last_d [2];
  logic          fifo_wp_q, fifo_wp_d;
  logic          fifo_rp_q, fifo_rp_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;

  logic          push_s;
  logic          pop_s;
  logic [2:0]    level_s;
  logic [AW:0]   rd_addr_s;

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[fifo_rp_q];
  assign out_last  = fifo_last_q[fifo_rp_q] & out_valid;
  assign ram_din   = in_data;

  // Next-state, RAM strobes and FIFO bookkeeping for the current cycle.
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    fifo_wp_d       = fifo_wp_q;
    fifo_rp_d       = fifo_rp_q;
    ram_ren         = 1'b0;
    ram_wen         = 1'b0;
    ram_addr        = {AW{1'b0}};
    // RAM data is only trusted the cycle after a read was issued.
    push_s          = inflight_q;
    pop_s           = out_valid & out_ready;
    // Entries the FIFO will hold once the in-flight read lands and any pop retires.
    level_s         = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
`ifdef RS_FRAME_REVERSE_EN
    rd_addr_s       = LAST_IDX - rd_ptr_q;
`else
    rd_addr_s       = rd_ptr_q;
`endif

    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          ram_wen  = 1'b1;
          ram_addr = wr_ptr_q[AW-1:0];
          if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d = PTR_ZERO;
            state_d  = ST_DRAIN;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      ST_DRAIN: begin
        if ((rd_ptr_q < FRAME_CNT) && (level_s < 3'd2)) begin
          ram_ren         = 1'b1;
          ram_addr        = rd_addr_s[AW-1:0];
          rd_ptr_d        = rd_ptr_q + PTR_ONE;
          inflight_d      = 1'b1;
          inflight_last_d = (rd_ptr_q == LAST_IDX);
        end else begin
          inflight_d      = 1'b0;
          inflight_last_d = 1'b0;
        end
        // The last-flagged entry leaving the FIFO closes the frame.
        if (pop_s && out_last) begin
          state_d  = ST_FILL;
          rd_ptr_d = PTR_ZERO;
        end else begin
          state_d  = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    if (push_s) begin
      fifo_data_d[fifo_wp_q] = ram_dout;
      fifo_last_d[fifo_wp_q] = inflight_last_q;
      fifo_wp_d              = ~fifo_wp_q;
    end else begin
      fifo_wp_d              = fifo_wp_q;
    end
    if (pop_s) begin
      fifo_rp_d = ~fifo_rp_q;
    end else begin
      fifo_rp_d = fifo_rp_q;
    end
    fifo_cnt_d = fifo_cnt_q + {1'b0, push_s} - {1'b0, pop_s};
  end

  // State, pointers and FIFO storage; async reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_FILL;
      wr_ptr_q        <= PTR_ZERO;
      rd_ptr_q        <= PTR_ZERO;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= {DW{1'b0}};
      fifo_data_q[1]  <= {DW{1'b0}};
      fifo_last_q[0]  <= 1'b0;
      fifo_last_q[1]  <= 1'b0;
      fifo_wp_q       <= 1'b0;
      fifo_rp_q       <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      fifo_wp_q       <= fifo_wp_d;
      fifo_rp_q       <= fifo_rp_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_rs_frame_buffer_ctrl.sv
// Bench for rs_frame_buffer_ctrl: RAM model, frame-level reference model,
// latency table for the first frame, and directed/random frame sequences.
module tb_rs_frame_buffer_ctrl;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int FL = 32;
`ifdef RS_FRAME_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = 16'h0000;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          ram_ren, ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  wire  [DW-1:0] ram_dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rs_frame_buffer_ctrl #(.WORDS(32), .AW(AW), .DW(DW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered read, driven only the cycle after a read.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_data = 16'h0000;
  logic          rd_vld = 1'b0;
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    rd_vld  <= ram_ren;
    rd_data <= mem[ram_addr];
  end
  assign ram_dout = rd_vld ? rd_data : 16'hzzzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready driver: 0=always 1, 1=pattern 1,0,0,1, 2=random.
  int rdy_mode = 0;
  initial begin : rdy_drv
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        2: out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b1;
      endcase
      ph++;
    end
  end

  // Reference model state (frame level).
  bit            exp_fill = 1'b1;
  int            wr_cnt = 0;
  logic [DW-1:0] fbuf [FL];
  logic [DW-1:0] exp_q [$];
  int            issued = 0, popped = 0;
  int            wen_total = 0, frames_done = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Per-cycle monitor/scoreboard sampled on the falling edge.
  initial forever begin : mon
    bit acc, pop;
    @(negedge clk);
    if (!rst_n) begin
      exp_fill = 1'b1; wr_cnt = 0; exp_q.delete(); issued = 0; popped = 0; prev_stall = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ram_en", {30'd0, ram_ren, ram_wen}, 32'd0);
      chk("rst_ram_addr", {27'd0, ram_addr}, 32'd0);
    end else begin
      acc = in_valid && exp_fill;
      pop = out_valid && out_ready;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_fill});
      chk("ram_wen", {31'd0, ram_wen}, {31'd0, acc});
      chk("ren_and_wen", {31'd0, ram_ren && ram_wen}, 32'd0);
      if (!ram_wen && !ram_ren) chk("idle_addr", {27'd0, ram_addr}, 32'd0);
      if (acc) begin
        chk("wr_addr", {27'd0, ram_addr}, wr_cnt);
        fbuf[wr_cnt] = in_data;
        wr_cnt++;
        wen_total++;
        if (wr_cnt == FL) begin
          for (int i = 0; i < FL; i++) exp_q.push_back(REV ? fbuf[FL-1-i] : fbuf[i]);
          exp_fill = 1'b0;
          wr_cnt = 0;
        end
      end
      if (ram_ren) chk("fifo_room", (issued - popped - int'(pop)) < 2, 32'd1);
      if (out_valid) begin
        chk("out_data_known", {31'd0, $isunknown(out_data)}, 32'd0);
        chk("no_dead", {31'd0, out_data == 16'hDEAD}, 32'd0);
      end
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pop", 32'd1, 32'd0);
        end else begin
          chk("out_data", {16'd0, out_data}, {16'd0, exp_q[0]});
          chk("out_last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            exp_fill = 1'b1;
            frames_done++;
          end
        end
      end
      issued += int'(ram_ren);
      popped += int'(pop);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  function automatic logic [DW-1:0] rnd_sym();
    logic [DW-1:0] v;
    v = 16'($urandom);
    if (v == 16'hDEAD) v = 16'hBEEF;
    return v;
  endfunction

  int last_acc_cyc = 0;

  // Sends n symbols; caller and task both sit at posedge+1.
  task automatic send(input int n, input logic [DW-1:0] base, input bit rnd, input bit gaps);
    int sent;
    int guard;
    logic [DW-1:0] d;
    sent = 0;
    guard = 0;
    d = rnd ? rnd_sym() : base;
    while (sent < n && guard < 5000) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = d;
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        last_acc_cyc = cyc;
        d = rnd ? rnd_sym() : base + 16'(sent);
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    chk("send_count", sent, n);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(exp_fill && exp_q.size() == 0 && !out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", {31'd0, n < budget}, 32'd1);
  endtask

  function automatic logic [DW-1:0] sym_a(input int idx);
    return REV ? 16'h1000 + 16'(FL - 1 - idx) : 16'h1000 + 16'(idx);
  endfunction

  typedef struct {
    int            k;
    logic          ir;
    logic          ren;
    logic          ov;
    bit            cd;
    logic [DW-1:0] od;
    logic          ol;
  } lat_row_t;

  lat_row_t lat [6];

  initial begin : main
    int c, w0, fd0;
    lat[0] = '{k: 1,  ir: 1'b0, ren: 1'b1, ov: 1'b0, cd: 1'b0, od: 16'h0000, ol: 1'b0};
    lat[1] = '{k: 2,  ir: 1'b0, ren: 1'b1, ov: 1'b0, cd: 1'b0, od: 16'h0000, ol: 1'b0};
    lat[2] = '{k: 3,  ir: 1'b0, ren: 1'b1, ov: 1'b1, cd: 1'b1, od: sym_a(0),  ol: 1'b0};
    lat[3] = '{k: 4,  ir: 1'b0, ren: 1'b1, ov: 1'b1, cd: 1'b1, od: sym_a(1),  ol: 1'b0};
    lat[4] = '{k: 34, ir: 1'b0, ren: 1'b0, ov: 1'b1, cd: 1'b1, od: sym_a(31), ol: 1'b1};
    lat[5] = '{k: 35, ir: 1'b1, ren: 1'b0, ov: 1'b0, cd: 1'b0, od: 16'h0000, ol: 1'b0};

    // Reset, then release with in_valid low.
    repeat (3) @(posedge clk);
    #7 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_out_data", {16'd0, out_data}, 32'd0);
    chk("post_rst_out_last", {31'd0, out_last}, 32'd0);

    // Frame A back-to-back, out_ready high, latency table.
    rdy_mode = 0;
    w0 = wen_total;
    send(FL, 16'h1000, 1'b0, 1'b0);
    c = last_acc_cyc;
    foreach (lat[i]) begin
      do @(negedge clk); while (cyc < c + lat[i].k);
      chk($sformatf("lat%0d_in_ready", lat[i].k), {31'd0, in_ready}, {31'd0, lat[i].ir});
      chk($sformatf("lat%0d_ram_ren", lat[i].k), {31'd0, ram_ren}, {31'd0, lat[i].ren});
      chk($sformatf("lat%0d_out_valid", lat[i].k), {31'd0, out_valid}, {31'd0, lat[i].ov});
      if (lat[i].cd) begin
        chk($sformatf("lat%0d_out_data", lat[i].k), {16'd0, out_data}, {16'd0, lat[i].od});
        chk($sformatf("lat%0d_out_last", lat[i].k), {31'd0, out_last}, {31'd0, lat[i].ol});
      end
    end
    @(posedge clk);
    #1;
    chk("frameA_wen_cycles", wen_total - w0, FL);
    chk("frameA_done", frames_done, 1);

    // Same frame with out_ready pattern 1,0,0,1.
    rdy_mode = 1;
    send(FL, 16'h1000, 1'b0, 1'b0);
    wait_idle(400);
    chk("toggle_done", frames_done, 2);

    // in_valid held with 0xDEAD during DRAIN.
    rdy_mode = 0;
    send(FL, 16'h3000, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle(100);
    chk("dead_done", frames_done, 3);

    // Async reset after 17 symbols, then a clean frame.
    send(17, 16'h1500, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ram", {30'd0, ram_ren, ram_wen}, 32'd0);
    chk("mid_rst_addr", {27'd0, ram_addr}, 32'd0);
    chk("mid_rst_out_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    fd0 = frames_done;
    send(FL, 16'h2000, 1'b0, 1'b0);
    wait_idle(100);
    chk("post_rst_frame", frames_done - fd0, 1);

    // Random frames, random gaps, random backpressure.
    rdy_mode = 2;
    fd0 = frames_done;
    for (int f = 0; f < 4; f++) send(FL, 16'h0000, 1'b1, 1'b1);
    wait_idle(600);
    chk("random_frames", frames_done - fd0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
